sdram_arbiter: RTL and testbench

- Shares the single chipset/CPU slot of the 96 MHz SDRAM controller between four requesters: video, CPU, blitter and DMA.
- One SDRAM access per 8 MHz slot. Each slot is bounded by consecutive clk_8_en pulses.
- Video has fixed top priority. CPU, blitter and DMA share the remaining slots round-robin.
- Guarantees an idle slot periodically, so the controller issues its auto-refresh in idle slots.

---
 rtl/sdram_arbiter.sv | 175 +++++++++++++++++
 tb/tb_sdram_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// Grants the shared SDRAM slot to video, CPU, blitter or DMA once per 8 MHz strobe.
// Video has fixed priority; the other three rotate. Refresh slots are forced periodically.
module sdram_arbiter #(
  parameter int REFRESH_MAX = 8
) (
  input  logic        clk_96,
  input  logic        init_n,
  input  logic        clk_8_en,
  input  logic        vid_req,
  input  logic [23:0] vid_addr,
  output logic        vid_ack,
  output logic [63:0] vid_data,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [23:0] cpu_addr,
  input  logic [1:0]  cpu_ds,
  input  logic [15:0] cpu_din,
  output logic        cpu_ack,
  output logic [15:0] cpu_dout,
  input  logic        blt_req,
  input  logic        blt_we,
  input  logic [23:0] blt_addr,
  input  logic [1:0]  blt_ds,
  input  logic [15:0] blt_din,
  output logic        blt_ack,
  output logic [15:0] blt_dout,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [23:0] dma_addr,
  input  logic [15:0] dma_din,
  output logic        dma_ack,
  output logic [15:0] dma_dout,
  output logic        ram_oe,
  output logic        ram_we,
  output logic [23:0] ram_addr,
  output logic [1:0]  ram_ds,
  output logic [15:0] ram_din,
  input  logic [15:0] ram_dout,
  input  logic [63:0] ram_dout64,
  output logic [2:0]  slot_owner,
  output logic        refresh_forced
);

  // state    | meaning
  // OWN_IDLE | no access this slot (nothing pending, or forced refresh)
  // OWN_VID  | video 64-bit burst read in progress
  // OWN_CPU  | CPU access in progress
  // OWN_BLT  | blitter access in progress
  // OWN_DMA  | DMA access in progress
  typedef enum logic [2:0] {
    OWN_IDLE = 3'd0,
    OWN_VID  = 3'd1,
    OWN_CPU  = 3'd2,
    OWN_BLT  = 3'd3,
    OWN_DMA  = 3'd4
  } owner_t;

  owner_t      owner;
  owner_t      rr_win;
  owner_t      win;
  logic [1:0]  rr_ptr;
  logic [1:0]  rr_next;
  logic [3:0]  busy_cnt;
  logic [2:0]  rr_elig;
  logic        forced;
  logic [23:0] nxt_addr;
  logic [1:0]  nxt_ds;
  logic [15:0] nxt_din;
  logic        nxt_we;

  assign slot_owner = owner;

  function automatic logic [1:0] rr_idx(input logic [1:0] base, input int k);
    int s;
    s = int'(base) + k;
    return 2'(s % 3);
  endfunction

  // The port finishing now must not win the very next slot on its still-high req.
  // Video is exempt: it streams, so a held vid_req means "keep fetching".
  assign rr_elig = {dma_req && owner != OWN_DMA,
                    blt_req && owner != OWN_BLT,
                    cpu_req && owner != OWN_CPU};

  assign forced = (busy_cnt == 4'(REFRESH_MAX));

  always_comb begin
    rr_win  = OWN_IDLE;
    rr_next = rr_ptr;
    for (int k = 0; k < 3; k++) begin
      if (rr_win == OWN_IDLE && rr_elig[rr_idx(rr_ptr, k)]) begin
        rr_win  = owner_t'(3'(rr_idx(rr_ptr, k)) + 3'd2);
        rr_next = rr_idx(rr_ptr, k + 1);
      end
    end
  end

  always_comb begin
    if (forced)       win = OWN_IDLE;
    else if (vid_req) win = OWN_VID;
    else              win = rr_win;
  end

  always_comb begin
    nxt_addr = ram_addr;
    nxt_ds   = ram_ds;
    nxt_din  = ram_din;
    nxt_we   = 1'b0;
    case (win)
      OWN_VID: begin nxt_addr = vid_addr; nxt_ds = 2'b11;  nxt_din = 16'h0;   nxt_we = 1'b0;   end
      OWN_CPU: begin nxt_addr = cpu_addr; nxt_ds = cpu_ds; nxt_din = cpu_din; nxt_we = cpu_we; end
      OWN_BLT: begin nxt_addr = blt_addr; nxt_ds = blt_ds; nxt_din = blt_din; nxt_we = blt_we; end
      OWN_DMA: begin nxt_addr = dma_addr; nxt_ds = 2'b11;  nxt_din = dma_din; nxt_we = dma_we; end
      default: ;
    endcase
  end

  always_ff @(posedge clk_96 or negedge init_n) begin
    if (!init_n) begin
      owner          <= OWN_IDLE;
      rr_ptr         <= 2'd0;
      busy_cnt       <= 4'd0;
      refresh_forced <= 1'b0;
      ram_oe         <= 1'b0;
      ram_we         <= 1'b0;
      ram_addr       <= 24'h0;
      ram_ds         <= 2'b00;
      ram_din        <= 16'h0;
      vid_ack        <= 1'b0;
      cpu_ack        <= 1'b0;
      blt_ack        <= 1'b0;
      dma_ack        <= 1'b0;
      vid_data       <= 64'h0;
      cpu_dout       <= 16'h0;
      blt_dout       <= 16'h0;
      dma_dout       <= 16'h0;
    end else begin
      vid_ack <= 1'b0;
      cpu_ack <= 1'b0;
      blt_ack <= 1'b0;
      dma_ack <= 1'b0;
      if (clk_8_en) begin
        vid_ack <= (owner == OWN_VID);
        cpu_ack <= (owner == OWN_CPU);
        blt_ack <= (owner == OWN_BLT);
        dma_ack <= (owner == OWN_DMA);
        if (ram_oe) begin
          case (owner)
            OWN_VID: vid_data <= ram_dout64;
            OWN_CPU: cpu_dout <= ram_dout;
            OWN_BLT: blt_dout <= ram_dout;
            OWN_DMA: dma_dout <= ram_dout;
            default: ;
          endcase
        end
        owner          <= win;
        refresh_forced <= forced;
        if (win != OWN_IDLE) begin
          ram_addr <= nxt_addr;
          ram_ds   <= nxt_ds;
          ram_din  <= nxt_din;
          ram_we   <= nxt_we;
          ram_oe   <= !nxt_we;
          if (!forced) busy_cnt <= busy_cnt + 4'd1;
        end else begin
          ram_oe   <= 1'b0;
          ram_we   <= 1'b0;
          busy_cnt <= 4'd0;
        end
        if (!forced && !vid_req && rr_win != OWN_IDLE) rr_ptr <= rr_next;
      end
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: a per-slot behavioural model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_sdram_arbiter;
  localparam int REFRESH_MAX = 8;

  logic        clk_96 = 1'b0;
  logic        init_n = 1'b1;
  logic        clk_8_en = 1'b0;
  logic        vid_req = 0, cpu_req = 0, blt_req = 0, dma_req = 0;
  logic        cpu_we = 0, blt_we = 0, dma_we = 0;
  logic [23:0] vid_addr = 0, cpu_addr = 0, blt_addr = 0, dma_addr = 0;
  logic [1:0]  cpu_ds = 0, blt_ds = 0;
  logic [15:0] cpu_din = 0, blt_din = 0, dma_din = 0;
  logic [15:0] ram_dout = 0;
  logic [63:0] ram_dout64 = 0;
  logic        vid_ack, cpu_ack, blt_ack, dma_ack;
  logic [63:0] vid_data;
  logic [15:0] cpu_dout, blt_dout, dma_dout;
  logic        ram_oe, ram_we, refresh_forced;
  logic [23:0] ram_addr;
  logic [1:0]  ram_ds;
  logic [15:0] ram_din;
  logic [2:0]  slot_owner;

  sdram_arbiter #(.REFRESH_MAX(REFRESH_MAX)) dut (
    .clk_96(clk_96), .init_n(init_n), .clk_8_en(clk_8_en),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_data(vid_data),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_ds(cpu_ds),
    .cpu_din(cpu_din), .cpu_ack(cpu_ack), .cpu_dout(cpu_dout),
    .blt_req(blt_req), .blt_we(blt_we), .blt_addr(blt_addr), .blt_ds(blt_ds),
    .blt_din(blt_din), .blt_ack(blt_ack), .blt_dout(blt_dout),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_din(dma_din),
    .dma_ack(dma_ack), .dma_dout(dma_dout),
    .ram_oe(ram_oe), .ram_we(ram_we), .ram_addr(ram_addr), .ram_ds(ram_ds),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_dout64(ram_dout64),
    .slot_owner(slot_owner), .refresh_forced(refresh_forced)
  );

  always #5 clk_96 = ~clk_96;

  int phase = 0;
  initial forever begin
    @(posedge clk_96);
    #1;
    phase = (phase + 1) % 12;
    clk_8_en = (phase == 0);
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: ports numbered 1=vid 2=cpu 3=blt 4=dma; one update per slot strobe.
  int          m_owner, m_ptr, m_run;
  bit          m_forced, m_oe, m_we;
  logic [23:0] m_addr;
  logic [1:0]  m_ds;
  logic [15:0] m_din;
  bit          m_ack [1:4];
  logic [15:0] m_dout [2:4];
  logic [63:0] m_vid;

  task automatic model_reset();
    m_owner = 0; m_ptr = 0; m_run = 0;
    m_forced = 0; m_oe = 0; m_we = 0;
    m_addr = 0; m_ds = 0; m_din = 0; m_vid = 0;
    for (int p = 1; p <= 4; p++) m_ack[p] = 0;
    for (int p = 2; p <= 4; p++) m_dout[p] = 0;
  endtask

  task automatic model_step();
    bit rq [1:4];
    int win;
    bit frc;
    for (int p = 1; p <= 4; p++) m_ack[p] = 0;
    if (!clk_8_en) return;
    if (m_owner != 0) m_ack[m_owner] = 1;
    if (m_oe && m_owner == 1) m_vid = ram_dout64;
    else if (m_oe && m_owner >= 2) m_dout[m_owner] = ram_dout;
    rq[1] = vid_req; rq[2] = cpu_req; rq[3] = blt_req; rq[4] = dma_req;
    win = 0;
    frc = (m_run == REFRESH_MAX);
    if (!frc) begin
      if (rq[1]) win = 1;
      else begin
        for (int k = 0; k < 3; k++) begin
          int port;
          port = 2 + (m_ptr + k) % 3;
          if (win == 0 && rq[port] && port != m_owner) begin
            win = port;
            m_ptr = (port - 1) % 3;
          end
        end
      end
    end
    m_forced = frc;
    m_owner = win;
    if (win == 0) begin
      m_oe = 0; m_we = 0; m_run = 0;
    end else begin
      m_run = (m_run < REFRESH_MAX) ? m_run + 1 : REFRESH_MAX;
      case (win)
        1: begin m_addr = vid_addr; m_ds = 2'b11;  m_din = 0;       m_we = 0;      end
        2: begin m_addr = cpu_addr; m_ds = cpu_ds; m_din = cpu_din; m_we = cpu_we; end
        3: begin m_addr = blt_addr; m_ds = blt_ds; m_din = blt_din; m_we = blt_we; end
        default: begin m_addr = dma_addr; m_ds = 2'b11; m_din = dma_din; m_we = dma_we; end
      endcase
      m_oe = !m_we;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk_96 or negedge init_n);
      if (!init_n) model_reset();
      else model_step();
    end
  end

  bit cmp_en = 0;
  initial forever begin
    @(negedge clk_96);
    if (cmp_en) begin
      check("owner", 64'(slot_owner), 64'(m_owner));
      check("refresh_forced", 64'(refresh_forced), 64'(m_forced));
      check("ram_oe", 64'(ram_oe), 64'(m_oe));
      check("ram_we", 64'(ram_we), 64'(m_we));
      check("ram_addr", 64'(ram_addr), 64'(m_addr));
      check("ram_ds", 64'(ram_ds), 64'(m_ds));
      check("ram_din", 64'(ram_din), 64'(m_din));
      check("vid_ack", 64'(vid_ack), 64'(m_ack[1]));
      check("cpu_ack", 64'(cpu_ack), 64'(m_ack[2]));
      check("blt_ack", 64'(blt_ack), 64'(m_ack[3]));
      check("dma_ack", 64'(dma_ack), 64'(m_ack[4]));
      check("cpu_dout", 64'(cpu_dout), 64'(m_dout[2]));
      check("blt_dout", 64'(blt_dout), 64'(m_dout[3]));
      check("dma_dout", 64'(dma_dout), 64'(m_dout[4]));
      check("vid_data", vid_data, m_vid);
    end
  end

  task automatic wait_slot();
    do @(posedge clk_96); while (!clk_8_en);
    #1;
  endtask

  int rr_exp [6] = '{3, 4, 2, 3, 4, 2};
  bit saw_ack;

  initial begin
    #2 init_n = 1'b0;
    cmp_en = 1;
    repeat (3) @(posedge clk_96);
    #1 init_n = 1'b1;
    check("lit_reset_owner", 64'(slot_owner), 64'd0);
    check("lit_reset_oe", 64'(ram_oe), 64'd0);
    wait_slot();

    // Single CPU write
    cpu_req = 1; cpu_we = 1; cpu_addr = 24'h001234; cpu_ds = 2'b01; cpu_din = 16'hBEEF;
    wait_slot();
    check("lit_wr_owner", 64'(slot_owner), 64'd2);
    check("lit_wr_we", 64'(ram_we), 64'd1);
    check("lit_wr_oe", 64'(ram_oe), 64'd0);
    check("lit_wr_addr", 64'(ram_addr), 64'h001234);
    check("lit_wr_ds", 64'(ram_ds), 64'h1);
    check("lit_wr_din", 64'(ram_din), 64'hBEEF);
    wait_slot();
    check("lit_wr_ack", 64'(cpu_ack), 64'd1);
    check("lit_wr_dout", 64'(cpu_dout), 64'd0);
    cpu_req = 0; cpu_we = 0;
    @(posedge clk_96); #1;
    check("lit_wr_ack_pulse", 64'(cpu_ack), 64'd0);

    // Video read
    vid_req = 1; vid_addr = 24'h000400; ram_dout64 = 64'h0123456789ABCDEF;
    wait_slot();
    check("lit_vid_owner", 64'(slot_owner), 64'd1);
    check("lit_vid_ds", 64'(ram_ds), 64'h3);
    check("lit_vid_oe", 64'(ram_oe), 64'd1);
    check("lit_vid_addr", 64'(ram_addr), 64'h000400);
    vid_req = 0;
    wait_slot();
    check("lit_vid_ack", 64'(vid_ack), 64'd1);
    check("lit_vid_data", vid_data, 64'h0123456789ABCDEF);

    // Round-robin contention; pointer sits at blitter after the CPU write
    cpu_we = 0; cpu_addr = 24'h000100; cpu_ds = 2'b10;
    blt_we = 1; blt_addr = 24'h000200; blt_ds = 2'b11; blt_din = 16'h5A5A;
    dma_we = 0; dma_addr = 24'h000300;
    cpu_req = 1; blt_req = 1; dma_req = 1;
    for (int i = 0; i < 6; i++) begin
      ram_dout = 16'h1000 + 16'(i);
      wait_slot();
      check("lit_rr_owner", 64'(slot_owner), 64'(rr_exp[i]));
    end
    cpu_req = 0; blt_req = 0; dma_req = 0;
    ram_dout = 16'h2222;
    wait_slot();
    check("lit_rr_cpu_dout", 64'(cpu_dout), 64'h2222);
    check("lit_rr_dma_dout", 64'(dma_dout), 64'h1005);
    check("lit_rr_blt_dout", 64'(blt_dout), 64'h0);

    // Video priority with forced refresh every ninth slot
    vid_req = 1; vid_addr = 24'h000800; ram_dout64 = 64'hFEDCBA9876543210;
    cpu_req = 1; cpu_we = 0;
    for (int i = 0; i < 18; i++) begin
      wait_slot();
      check("lit_ref_owner", 64'(slot_owner), (i % 9 == 8) ? 64'd0 : 64'd1);
      check("lit_ref_forced", 64'(refresh_forced), (i % 9 == 8) ? 64'd1 : 64'd0);
      if (i % 9 == 8) check("lit_ref_oe", 64'(ram_oe), 64'd0);
    end
    vid_req = 0;
    wait_slot();
    check("lit_cpu_after_vid", 64'(slot_owner), 64'd2);
    cpu_req = 0;
    wait_slot();

    // Reset mid-slot
    cpu_req = 1; cpu_we = 0; cpu_addr = 24'h00ABCD;
    wait_slot();
    check("lit_rst_granted", 64'(slot_owner), 64'd2);
    repeat (4) @(posedge clk_96);
    #1 init_n = 1'b0;
    cpu_req = 0;
    #1;
    check("lit_rst_owner", 64'(slot_owner), 64'd0);
    check("lit_rst_oe", 64'(ram_oe), 64'd0);
    check("lit_rst_addr", 64'(ram_addr), 64'd0);
    check("lit_rst_cpu_dout", 64'(cpu_dout), 64'd0);
    check("lit_rst_vid_data", vid_data, 64'd0);
    repeat (2) @(posedge clk_96);
    #1 init_n = 1'b1;
    saw_ack = 0;
    repeat (30) begin
      @(negedge clk_96);
      if (cpu_ack) saw_ack = 1;
    end
    check("lit_rst_no_ack", 64'(saw_ack), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
